oh_rseq: RTL
============

// Module: oh_rseq
// PURPOSE
// - Reset synchronizer and sequencer. Asserts all outputs asynchronously on
//   nrst_in low. Releases them synchronously to clk, one at a time in index order.
// - Guarantees a minimum synchronous reset width, a fixed gap between releases,
//   and supports a software-requested re-reset.
// - Sits at a clock-domain root and feeds ordered resets to dependent subsystems
//   (e.g. PHY before MAC before fabric).
// PARAMETERS
// - PS    2   synchronizer stages; legal range >=2
// - N     4   number of sequenced reset outputs; legal range >=1
// - HOLD  16  cycles all outputs stay low after synchronized deassert; legal range >=1
// - GAP   8   cycles between successive output releases; legal range >=1
// - CW    derived localparam = clog2(max(HOLD,GAP)+1); not user-set
// PORTS
// - clk       in   1  clock
// - nrst_in   in   1  reset, asynchronous, active-low
// - sw_rst    in   1  synchronous software reset request, active-high, level
// - nrst_out  out  N  sequenced resets, active-low; bit 0 releases first
// - busy      out  1  high while any output is still held in reset
// - done      out  1  high when all N outputs are released
// BEHAVIOUR
// - Reset (nrst_in low), asynchronous and immediate:
//   - nrst_out=0, busy=1, done=0
//   - FSM=RST, counters=0, sync pipe=0
//   - Applies from any state, including mid-sequence.
// - Deassert: nrst_in passes through the PS-stage synchronizer -> srst_n.
//   - Edge 1 is the first posedge with nrst_in high.
//   - srst_n is high after edge PS.
// - FSM states and transitions:
//   - RST:  leave when srst_n=1 -> HOLD; load cnt=HOLD-1.
//   - HOLD: decrement cnt each cycle.
//     - At cnt==0 -> SEQ, release nrst_out[0], idx=1, cnt=GAP-1.
//     - If N==1 -> DONE directly.
//   - SEQ:  decrement cnt each cycle.
//     - At cnt==0: release nrst_out[idx], idx++, reload cnt=GAP-1.
//     - Move to DONE on the same edge that releases nrst_out[N-1].
//   - DONE: hold; busy=0, done=1.
// - Release timing:
//   - nrst_out[k] rises after edge PS+HOLD+k*GAP.
//   - Defaults: bit0 @18, bit1 @26, bit2 @34, bit3 @42.
//   - done and busy change on the edge that releases bit N-1.
// - Released outputs stay high until the next reset or sw_rst.
// - Output ordering invariant: nrst_out is always a thermometer code; bit k
//   high implies bits 0..k-1 high.
// - sw_rst handling:
//   - Sampled only when srst_n=1; state HOLD, SEQ or DONE.
//   - Next edge: nrst_out=0, busy=1, done=0, FSM=HOLD, cnt=HOLD-1, idx=0.
//   - While sw_rst stays high, FSM remains in HOLD with cnt held at HOLD-1.
//   - Countdown starts on the first edge with sw_rst low.
//   - In RST, sw_rst is ignored.
// - Simultaneous events:
//   - nrst_in low overrides everything.
//   - sw_rst overrides a release due on the same edge; that release does not happen.
// - All outputs are driven directly from flops with async clear by nrst_in.
//   - No combinational logic on the nrst_out path; outputs are glitch-free.
// - Counter widths: cnt is CW bits and never underflows (reloaded at 0).
//   - idx is clog2(N+1) bits.
// STRUCTURE
// - Sub-module: oh_rsync #(.PS(PS)) produces srst_n from nrst_in.
// - Constants: FSM encodings RST/HOLD/SEQ/DONE as a 2-bit localparam set.
//   - They go in the shared common defs header so status decode in other blocks
//     can reuse them.
// - Everything else (counters, FSM, thermometer output register) stays local
//   to this module.
// TESTING
// - Defaults; nrst_in low 5 cycles, then high at edge 1
//   -> nrst_out 0000 until edge 18, then 0001, 0011@26, 0111@34, 1111@42;
//      done=1 @42.
// - Pulse nrst_in low for 1ns mid-SEQ (nrst_out=0011)
//   -> nrst_out=0000, busy=1 within the same cycle, no clock needed;
//      re-sequence gives bit0 @18 after release.
// - In DONE, sw_rst=1 for 3 cycles
//   -> nrst_out=0000 on the next edge; bit0 rises 16 edges after sw_rst falls.
// - sw_rst asserted on the edge where bit2 is due
//   -> bit2 is not released; all outputs go low; sequence restarts from HOLD.
// - PS=3, N=1, HOLD=1, GAP=1
//   -> nrst_out[0] and done rise after edge 4; busy falls on the same edge.
// - Random nrst_in/sw_rst over 10k cycles
//   -> assertions: thermometer invariant, done==&nrst_out, busy==~done,
//      gaps between consecutive releases are exactly GAP.

Source files
------------

// File: rtl/oh_rseq_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings (reusable by
// status decode elsewhere) and a small sizing helper.
package oh_rseq_pkg;

   localparam logic [1:0] RSEQ_ST_RST  = 2'd0;
   localparam logic [1:0] RSEQ_ST_HOLD = 2'd1;
   localparam logic [1:0] RSEQ_ST_SEQ  = 2'd2;
   localparam logic [1:0] RSEQ_ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      ST_RST  = RSEQ_ST_RST,
      ST_HOLD = RSEQ_ST_HOLD,
      ST_SEQ  = RSEQ_ST_SEQ,
      ST_DONE = RSEQ_ST_DONE
   } rseq_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/oh_rseq_rsync.sv
// Reset synchronizer: asynchronous assert, PS-stage synchronous release.
// srst_n_pre is the stage feeding the last flop, so it shows what srst_n
// will be after the next edge.
module oh_rsync #(
   parameter int PS = 2
) (
   input  logic clk,
   input  logic nrst_in,
   output logic srst_n,
   output logic srst_n_pre
);

   logic [PS-1:0] sync_r;

   // Shift ones in after reset release; clear the whole pipe on nrst_in low.
   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[PS-2:0], 1'b1};
      end
   end

   assign srst_n     = sync_r[PS-1];
   assign srst_n_pre = sync_r[PS-2];

endmodule

// File: rtl/oh_rseq.sv
// Reset sequencer: holds all outputs low for HOLD cycles after synchronized
// release, then releases them one at a time, GAP cycles apart, bit 0 first.
// sw_rst re-enters the hold phase. Every output comes straight from a flop.
module oh_rseq
   import oh_rseq_pkg::*;
#(
   parameter int PS   = 2,
   parameter int N    = 4,
   parameter int HOLD = 16,
   parameter int GAP  = 8
) (
   input  logic         clk,
   input  logic         nrst_in,
   input  logic         sw_rst,
   output logic [N-1:0] nrst_out,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(max2(HOLD, GAP) + 1);
   localparam int IW = $clog2(N + 1);

   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [N-1:0]  REL0     = N'(1);

   logic          srst_n_s;
   logic          srst_n_pre_s;

   rseq_state_t   state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [IW-1:0] idx_r, idx_s;
   logic [N-1:0]  nrst_out_r, nrst_out_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;

   oh_rsync #(.PS(PS)) u_rsync (
      .clk        (clk),
      .nrst_in    (nrst_in),
      .srst_n     (srst_n_s),
      .srst_n_pre (srst_n_pre_s)
   );

   // Next-state, counters and thermometer output; sw_rst preempts any release.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      idx_s      = idx_r;
      nrst_out_s = nrst_out_r;
      busy_s     = busy_r;
      done_s     = done_r;
      if ((state_r != ST_RST) && srst_n_s && sw_rst) begin
         state_s    = ST_HOLD;
         cnt_s      = HOLD_LD;
         idx_s      = '0;
         nrst_out_s = '0;
         busy_s     = 1'b1;
         done_s     = 1'b0;
      end else begin
         case (state_r)
            ST_RST: begin
               // Leave on the edge srst_n rises so HOLD is counted from srst_n.
               if (srst_n_pre_s) begin
                  state_s = ST_HOLD;
                  cnt_s   = HOLD_LD;
                  idx_s   = '0;
               end else begin
                  state_s = ST_RST;
               end
            end
            ST_HOLD: begin
               if (cnt_r == '0) begin
                  nrst_out_s = REL0;
                  if (N == 1) begin
                     state_s = ST_DONE;
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_SEQ;
                     idx_s   = IDX_ONE;
                     cnt_s   = GAP_LD;
                  end
               end else begin
                  cnt_s = cnt_r - 1'b1;
               end
            end
            ST_SEQ: begin
               if (cnt_r == '0) begin
                  nrst_out_s = (nrst_out_r << 1) | REL0;
                  idx_s      = idx_r + 1'b1;
                  cnt_s      = GAP_LD;
                  if (idx_r == IDX_LAST) begin
                     state_s = ST_DONE;
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_SEQ;
                  end
               end else begin
                  cnt_s = cnt_r - 1'b1;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_RST;
            end
         endcase
      end
   end

   // State and output flops, all cleared asynchronously by nrst_in.
   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
         state_r    <= ST_RST;
         cnt_r      <= '0;
         idx_r      <= '0;
         nrst_out_r <= '0;
         busy_r     <= 1'b1;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         idx_r      <= idx_s;
         nrst_out_r <= nrst_out_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

   assign nrst_out = nrst_out_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule
